// File: rtl/uart_rx_pkt_ctrl_if.sv
// uart_rx_pkt_ctrl_if: payload write bus from the packet controller.
// The controller drives it through master; the payload store listens on slave.
interface uart_rx_pkt_ctrl_if #(
  parameter int AW = 8
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data
  );
endinterface

// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl: frames SYNC/LEN/payload packets from an 8-bit UART rx.
// Define UART_PKT_CHECKSUM_EN to require a trailing checksum byte.
module uart_rx_pkt_ctrl #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [15:0] TIMEOUT   = 16'd2048,
  parameter int          AW        = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  output logic               o_rx_en,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_rx_err,
  uart_rx_pkt_ctrl_if.master wr,
  output logic [7:0]         o_pkt_len,
  output logic               o_pkt_done,
  output logic               o_pkt_err,
  output logic               o_busy
);

`ifdef UART_PKT_CHECKSUM_EN
  typedef enum logic [1:0] {
    S_IDLE, S_LEN, S_PAYLOAD, S_CSUM
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_LEN, S_PAYLOAD
  } state_t;
`endif

  state_t        r_state;
  logic          r_rx_en;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [7:0]    r_wr_data;
  logic [7:0]    r_pkt_len;
  logic          r_done;
  logic          r_err;
  logic [7:0]    r_len;
  logic [7:0]    r_idx;
  logic [15:0]   r_cnt;
`ifdef UART_PKT_CHECKSUM_EN
  logic [7:0]    r_sum;
`endif

  logic w_last;
  logic w_tmo;

  assign w_last = (r_idx == r_len - 8'd1);
  assign w_tmo  = (r_cnt == TIMEOUT - 16'd1);

  always_ff @(posedge i_clk) begin
    r_rx_en <= i_en;
    r_wr_en <= 1'b0;
    r_done  <= 1'b0;
    r_err   <= 1'b0;
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_rx_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_pkt_len <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
`ifdef UART_PKT_CHECKSUM_EN
      r_sum     <= '0;
`endif
    end else if (!i_en) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
      if (i_rx_done && i_rx_data == SYNC_BYTE)
        r_state <= S_LEN;
    end else if (i_rx_err) begin
      r_err   <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (i_rx_done) begin
      // a byte landing on the timeout cycle still counts
      r_cnt <= '0;
      unique case (r_state)
        S_LEN: begin
          if (i_rx_data == 8'd0) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_len     <= i_rx_data;
            r_idx     <= '0;
            r_wr_addr <= '0;
`ifdef UART_PKT_CHECKSUM_EN
            r_sum     <= '0;
`endif
            r_state   <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= AW'(r_idx);
          r_wr_data <= i_rx_data;
          r_idx     <= r_idx + 8'd1;
`ifdef UART_PKT_CHECKSUM_EN
          r_sum     <= r_sum + i_rx_data;
          if (w_last)
            r_state <= S_CSUM;
`else
          if (w_last) begin
            r_done    <= 1'b1;
            r_pkt_len <= r_len;
            r_state   <= S_IDLE;
          end
`endif
        end
`ifdef UART_PKT_CHECKSUM_EN
        S_CSUM: begin
          if (i_rx_data == 8'(r_len + r_sum)) begin
            r_done    <= 1'b1;
            r_pkt_len <= r_len;
          end else begin
            r_err <= 1'b1;
          end
          r_state <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end else if (w_tmo) begin
      r_err   <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_rx_en    = r_rx_en;
  assign wr.wr_en   = r_wr_en;
  assign wr.wr_addr = r_wr_addr;
  assign wr.wr_data = r_wr_data;
  assign o_pkt_len  = r_pkt_len;
  assign o_pkt_done = r_done;
  assign o_pkt_err  = r_err;
  assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// tb_uart_rx_pkt_ctrl: random and directed byte streams against a
// packet-level reference model; events compared with cycle stamps.
module tb_uart_rx_pkt_ctrl;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int TO = 2048;
  localparam int AW = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic       rx_en;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_err;
  logic [7:0] pkt_len;
  logic       pkt_done;
  logic       pkt_err;
  logic       busy;

  uart_rx_pkt_ctrl_if #(.AW(AW)) wb();

  uart_rx_pkt_ctrl #(
    .SYNC_BYTE(SYNC),
    .TIMEOUT(16'(TO)),
    .AW(AW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_en(en),
    .o_rx_en(rx_en),
    .i_rx_data(rx_data),
    .i_rx_done(rx_done),
    .i_rx_err(rx_err),
    .wr(wb.master),
    .o_pkt_len(pkt_len),
    .o_pkt_done(pkt_done),
    .o_pkt_err(pkt_err),
    .o_busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // event = {cycle, kind(1 wr,2 done,3 err), addr, data/len}
  function automatic logic [63:0] ev(input int c, input int k,
                                     input int a, input int d);
    return {c, k[7:0], a[15:0], d[7:0]};
  endfunction

  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];

  always @(negedge clk) begin
    if (wb.wr_en) obs_q.push_back(ev(cyc, 1, int'(wb.wr_addr), int'(wb.wr_data)));
    if (pkt_done) obs_q.push_back(ev(cyc, 2, 0, int'(pkt_len)));
    if (pkt_err)  obs_q.push_back(ev(cyc, 3, 0, int'(pkt_len)));
  end

  // reference model: packet parser over (byte, cycle) pairs
  bit in_pkt = 0;
  bit have_len = 0;
  int plen = 0;
  int pcnt = 0;
  int psum = 0;
  int last_c = 0;
  int last_len = 0;

  task automatic mdl_abort(input int c);
    exp_q.push_back(ev(c, 3, 0, last_len));
    in_pkt = 0;
  endtask

  task automatic mdl_expire(input int c);
    if (in_pkt && c - last_c > TO) mdl_abort(last_c + TO);
  endtask

  task automatic mdl_byte(input int b, input bit err, input int c);
    mdl_expire(c);
    if (!in_pkt) begin
      if (b == int'(SYNC)) begin
        in_pkt = 1;
        have_len = 0;
      end
    end else if (err) begin
      mdl_abort(c);
    end else if (!have_len) begin
      if (b == 0) mdl_abort(c);
      else begin
        have_len = 1;
        plen = b;
        pcnt = 0;
        psum = 0;
      end
    end else if (pcnt < plen) begin
      exp_q.push_back(ev(c, 1, pcnt % (1 << AW), b));
      pcnt++;
      psum = (psum + b) % 256;
`ifndef UART_PKT_CHECKSUM_EN
      if (pcnt == plen) begin
        last_len = plen;
        exp_q.push_back(ev(c, 2, 0, last_len));
        in_pkt = 0;
      end
`endif
    end else begin
      if (b == (plen + psum) % 256) begin
        last_len = plen;
        exp_q.push_back(ev(c, 2, 0, last_len));
        in_pkt = 0;
      end else begin
        mdl_abort(c);
      end
    end
    last_c = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap, input bit err);
    repeat (gap) tick();
    rx_data = b;
    rx_done = 1'b1;
    rx_err  = err;
    if (en) mdl_byte(int'(b), err, cyc + 1);
    tick();
    rx_done = 1'b0;
    rx_err  = 1'b0;
    chk("busy", 64'(busy), 64'(in_pkt));
  endtask

  task automatic send_pkt(input int len, input int gap,
                          input int err_at, input bit bad_cs);
    logic [7:0] b;
    int s;
    send(SYNC, gap, 1'b0);
    send(8'(len), gap, 1'b0);
    s = len;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      s = s + int'(b);
      send(b, gap, i == err_at);
    end
    s = s + int'(bad_cs);
`ifdef UART_PKT_CHECKSUM_EN
    send(8'(s), gap, 1'b0);
`endif
  endtask

  task automatic compare(input string tag);
    @(negedge clk);
    #1;
    chk({tag, "_cnt"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
    tick();
  endtask

  task automatic settle(input string tag);
    repeat (TO + 4) tick();
    mdl_expire(cyc + 1);
    compare(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mdl_expire(cyc + 1);
    in_pkt = 0;
    last_len = 0;
    tick();
    chk("rst_rx_en", 64'(rx_en), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_wr_en", 64'(wb.wr_en), 64'(0));
    chk("rst_wr_addr", 64'(wb.wr_addr), 64'(0));
    chk("rst_wr_data", 64'(wb.wr_data), 64'(0));
    chk("rst_pkt_len", 64'(pkt_len), 64'(0));
    chk("rst_done", 64'(pkt_done), 64'(0));
    chk("rst_err", 64'(pkt_err), 64'(0));
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en = 1'b0;
    rx_data = '0;
    rx_done = 1'b0;
    rx_err = 1'b0;
    tick();
    tick();
    do_reset();
    en = 1'b1;
    tick();
    chk("rx_en_on", 64'(rx_en), 64'(1));

    // basic packet, then same with a wrong checksum when enabled
    send(SYNC, 0, 0);
    send(8'h03, 0, 0);
    send(8'h11, 0, 0);
    send(8'h22, 1, 0);
    send(8'h33, 0, 0);
`ifdef UART_PKT_CHECKSUM_EN
    send(8'h69, 0, 0);
    send(SYNC, 2, 0);
    send(8'h03, 0, 0);
    send(8'h11, 0, 0);
    send(8'h22, 0, 0);
    send(8'h33, 0, 0);
    send(8'h00, 0, 0);
`endif
    settle("basic");

    // noise then zero length
    send(8'h7F, 0, 0);
    send(SYNC, 0, 0);
    send(8'h00, 0, 0);
    settle("len0");

    // timeout mid-packet, then a clean one-byte packet
    send(SYNC, 0, 0);
    send(8'h02, 0, 0);
    send(8'h44, 0, 0);
    send(SYNC, TO + 10, 0);
    send(8'h01, 0, 0);
    send(8'h55, 0, 0);
    send(8'h56, 0, 0);
    settle("tmo");

    // gap boundary: TO-1 idle cycles survives, TO idle cycles aborts
    send(SYNC, 0, 0);
    send(8'h03, 0, 0);
    send(8'h10, TO - 1, 0);
    send(8'h20, TO, 0);
    settle("tmo_edge");

    // framing error on payload byte 2 of 4
    send(SYNC, 0, 0);
    send(8'h04, 0, 0);
    send(8'hC1, 0, 0);
    send(8'hC2, 0, 1);
    send(8'hC3, 0, 0);
    settle("rxerr");

    // reset mid-packet
    send(SYNC, 0, 0);
    send(8'h05, 0, 0);
    send(8'hD1, 0, 0);
    do_reset();
    tick();
    settle("rst_mid");

    // enable drop mid-packet
    send(SYNC, 0, 0);
    send(8'h05, 0, 0);
    send(8'hE1, 0, 0);
    en = 1'b0;
    mdl_expire(cyc + 1);
    in_pkt = 0;
    tick();
    chk("en0_busy", 64'(busy), 64'(0));
    send(SYNC, 0, 0);
    chk("en0_rx_en", 64'(rx_en), 64'(0));
    en = 1'b1;
    tick();
    chk("en1_rx_en", 64'(rx_en), 64'(1));
    send_pkt(1, 0, -1, 0);
    settle("en_drop");

    // address wrap and maximum length
    send_pkt(37, 0, -1, 0);
    send_pkt(255, 0, -1, 0);
    settle("wrap");

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0)
        send(8'($urandom), $urandom_range(0, 2), 0);
      send_pkt($urandom_range(1, 24), $urandom_range(0, 2),
               ($urandom_range(0, 7) == 0) ? $urandom_range(0, 23) : -1,
               $urandom_range(0, 4) == 0);
    end
    settle("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_pkt_ctrl.md
UART_RX_PKT_CTRL -- requirements
Module: uart_rx_pkt_ctrl

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, packet start marker.
REQ-002 Parameter TIMEOUT, default 16'd2048, max clk cycles between consecutive bytes inside a packet.
REQ-003 Parameter AW, default 8, write-address width.
REQ-004 clk  in  1  receiver clock (same clk as the 8-bit UART receiver); single clock domain.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  controller enable.
REQ-007 rx_en  out  1  enable to receiver; equals en registered, 0 during rst.
REQ-008 rx_data  in  8  receiver output byte.
REQ-009 rx_done  in  1  receiver one-cycle byte-complete pulse.
REQ-010 rx_err  in  1  receiver framing error flag.
REQ-011 wr_en  out  1  payload write strobe.
REQ-012 wr_addr  out  AW  payload write address.
REQ-013 wr_data  out  8  payload write data.
REQ-014 pkt_len  out  8  length of last accepted packet.
REQ-015 pkt_done  out  1  one-cycle pulse, packet accepted.
REQ-016 pkt_err  out  1  one-cycle pulse, packet aborted (framing, length, timeout, checksum).
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 Packet format: SYNC_BYTE, LEN (1..255), LEN payload bytes, then CSUM when checksum is compiled in.
REQ-019 States: IDLE, LEN, PAYLOAD, CSUM; all transitions occur on a clk edge where rx_done=1, except the abort transitions defined in REQ-025 and REQ-026.
REQ-020 IDLE: rx_done with rx_data==SYNC_BYTE -> LEN; any other byte is discarded silently with no pkt_err.
REQ-021 LEN: rx_data==0 -> pkt_err, IDLE; else store LEN in an internal register, clear running sum and wr_addr -> PAYLOAD.
REQ-022 PAYLOAD: each rx_done -> wr_en=1 for exactly one cycle on the next edge, wr_data=rx_data, wr_addr=index 0..LEN-1; running sum += rx_data mod 256.
REQ-023 After the LEN-th payload byte -> CSUM (with checksum) or accept (without).
REQ-024 Accept: pkt_done=1 and pkt_len=LEN one cycle after the final rx_done -> IDLE; pkt_len holds until the next accept.
REQ-025 rx_err=1 in any non-IDLE state -> pkt_err pulse, IDLE; if rx_err and rx_done are high in the same cycle, rx_err wins and the byte is not written.
REQ-026 Inter-byte counter clears on each rx_done and on entry to LEN; reaching TIMEOUT in a non-IDLE state -> pkt_err, IDLE; if rx_done and timeout coincide, the byte is accepted and the counter clears.
REQ-027 wr_addr wraps modulo 2^AW when LEN > 2^AW; no error is raised.
REQ-028 en=0 mid-packet -> IDLE next edge, no pkt_err, no pkt_done, and wr_en=0; rx_done is ignored while en=0.
REQ-029 pkt_done and pkt_err never assert in the same cycle.

Reset
REQ-030 When rst=1, the following take effect on the next edge: state=IDLE; rx_en, wr_en, pkt_done, pkt_err, busy=0; wr_addr, wr_data, pkt_len, LEN register, sum and timeout counter=0.
REQ-031 A reset mid-packet discards the packet with no pulse.

Configuration
REQ-032 Macro UART_PKT_CHECKSUM_EN defined: CSUM state present; accept only if CSUM == (LEN + sum of payload) mod 256, else pkt_err.
REQ-033 UART_PKT_CHECKSUM_EN undefined: no CSUM state or sum register; accept directly after the last payload byte.

Verification
REQ-034 Bytes A5,03,11,22,33,69 (checksum on) -> wr_en at addr 0/1/2 with data 11/22/33; pkt_done=1 with pkt_len=3; no pkt_err.
REQ-035 Same stream with CSUM=00 -> three writes, then pkt_err=1, pkt_done=0, pkt_len unchanged.
REQ-036 Bytes 7F,A5,00 -> 7F dropped silently, then pkt_err pulses on LEN=0, no wr_en.
REQ-037 A5,02,44 then a 2048-cycle gap -> one write (addr0=44), then pkt_err at the timeout, IDLE; a following A5,01,55,56 -> pkt_done.
REQ-038 rx_err raised together with rx_done during payload byte 2 of 4 -> no write for that byte, pkt_err pulse; rst asserted mid-packet -> all outputs 0 next cycle, no pulse.
